// File: rtl/sdspi_word_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : sdspi_word_loader_if
// Brief    : Word write bus from the SD file loader to the memory init port.
// Revision : 1.0 - initial release
// ============================================================================
interface sdspi_word_loader_if #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [ADDR_W-1:0]       wr_addr;
    logic [8*WORD_BYTES-1:0] wr_data;
    logic [WORD_BYTES-1:0]   wr_strb;

    modport master (output wr_valid, wr_addr, wr_data, wr_strb, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, wr_strb, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/sdspi_word_loader.sv
`default_nettype none
// ============================================================================
// Module   : sdspi_word_loader
// Brief    : Packs the SD file byte stream LSB-first into words, queues them
//            and writes them to the memory init port over valid/ready.
//            Optional LOADER_CHECKSUM_EN adds a byte-sum checksum output.
// Revision : 1.0 - initial release
// ============================================================================
module sdspi_word_loader #(
    parameter int                WORD_BYTES = 4,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [31:0]       MAX_BYTES  = 32'h0010_0000,
    parameter int                FIFO_DEPTH = 4
) (
    input  wire logic           clk27mhz,
    input  wire logic           resetn,
    input  wire logic           start,
    input  wire logic           init_ok,
    input  wire logic           byte_en,
    input  wire logic [7:0]     byte_in,
    input  wire logic           byte_last,
    sdspi_word_loader_if.master wr,
    output logic                busy,
    output logic                done,
    output logic                overflow,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0]         checksum,
`endif
    output logic [31:0]         byte_count
);
    localparam int c_DATA_W = 8 * WORD_BYTES;
    localparam int c_LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_LANE_W-1:0]   r_fill;
    logic [c_DATA_W-1:0]   r_pack;
    logic [ADDR_W-1:0]     r_push_addr;
    logic [31:0]           r_byte_count;
    logic                  r_overflow;
    logic                  r_stage_valid;
    logic [ADDR_W-1:0]     r_stage_addr;
    logic [c_DATA_W-1:0]   r_stage_data;
    logic [WORD_BYTES-1:0] r_stage_strb;
    logic [c_PTR_W:0]      r_wptr;
    logic [c_PTR_W:0]      r_rptr;
    logic [ADDR_W-1:0]     r_mem_addr [FIFO_DEPTH];
    logic [c_DATA_W-1:0]   r_mem_data [FIFO_DEPTH];
    logic [WORD_BYTES-1:0] r_mem_strb [FIFO_DEPTH];
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]           r_checksum;
`endif

    logic                  w_accept;
    logic                  w_final;
    logic                  w_word_done;
    logic                  w_start_load;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic [c_DATA_W-1:0]   w_merged;
    logic [WORD_BYTES-1:0] w_strb_done;

    assign w_accept     = (r_state == S_LOAD) && init_ok && byte_en;
    assign w_final      = byte_last || (r_byte_count == MAX_BYTES - 32'd1);
    assign w_word_done  = w_accept && ((r_fill == c_LAST_LANE) || w_final);
    assign w_start_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_empty      = (r_wptr == r_rptr);
    assign w_full       = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                          (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);
    assign w_pop        = !w_empty && wr.wr_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push
    assign w_push       = r_stage_valid && (!w_full || w_pop);

    always_ff @(posedge clk27mhz) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_LOAD;
            S_LOAD:  if (w_accept && w_final) w_state_next = S_DRAIN;
            S_DRAIN: if (w_empty && !r_stage_valid) w_state_next = S_DONE;
            S_DONE:  if (start) w_state_next = S_LOAD;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_merged    = r_pack | (c_DATA_W'(byte_in) << {r_fill, 3'b000});
        w_strb_done = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            w_strb_done[k] = (k <= int'(r_fill));
        end
    end

    always_ff @(posedge clk27mhz) begin
        if (!resetn) begin
            r_fill        <= '0;
            r_pack        <= '0;
            r_push_addr   <= BASE_ADDR;
            r_byte_count  <= '0;
            r_overflow    <= 1'b0;
            r_stage_valid <= 1'b0;
            r_stage_addr  <= '0;
            r_stage_data  <= '0;
            r_stage_strb  <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_checksum    <= '0;
`endif
        end else begin
            // Staged word enters the FIFO one edge after it completes
            if (r_stage_valid) begin
                r_stage_valid <= 1'b0;
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end

            if (w_start_load) begin
                r_fill       <= '0;
                r_pack       <= '0;
                r_push_addr  <= BASE_ADDR;
                r_byte_count <= '0;
                r_overflow   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                r_checksum   <= '0;
`endif
            end else if (w_accept) begin
                if (r_byte_count != MAX_BYTES) begin
                    r_byte_count <= r_byte_count + 32'd1;
                end
`ifdef LOADER_CHECKSUM_EN
                r_checksum <= r_checksum + {24'd0, byte_in};
`endif
                if (w_word_done) begin
                    r_stage_valid <= 1'b1;
                    r_stage_addr  <= r_push_addr;
                    r_stage_data  <= w_merged;
                    r_stage_strb  <= w_strb_done;
                    r_push_addr   <= r_push_addr + ADDR_W'(WORD_BYTES);
                    r_fill        <= '0;
                    r_pack        <= '0;
                end else begin
                    r_pack <= w_merged;
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk27mhz) begin
        if (resetn && w_push) begin
            r_mem_addr[r_wptr[c_PTR_W-1:0]] <= r_stage_addr;
            r_mem_data[r_wptr[c_PTR_W-1:0]] <= r_stage_data;
            r_mem_strb[r_wptr[c_PTR_W-1:0]] <= r_stage_strb;
        end
    end

    always_comb begin
        busy        = (r_state == S_LOAD) || (r_state == S_DRAIN);
        done        = (r_state == S_DONE);
        wr.wr_valid = !w_empty;
        wr.wr_addr  = '0;
        wr.wr_data  = '0;
        wr.wr_strb  = '0;
        if (!w_empty) begin
            wr.wr_addr = r_mem_addr[r_rptr[c_PTR_W-1:0]];
            wr.wr_data = r_mem_data[r_rptr[c_PTR_W-1:0]];
            wr.wr_strb = r_mem_strb[r_rptr[c_PTR_W-1:0]];
        end
    end

    assign overflow   = r_overflow;
    assign byte_count = r_byte_count;
`ifdef LOADER_CHECKSUM_EN
    assign checksum   = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdspi_word_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdspi_word_loader
// Brief    : Randomised bench for sdspi_word_loader; two instances (default
//            and MAX_BYTES=10) run the same byte streams against a word model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdspi_word_loader;
    localparam int          c_WB        = 4;
    localparam int          c_DEPTH     = 4;
    localparam logic [31:0] c_MAX_BIG   = 32'h0010_0000;
    localparam logic [31:0] c_MAX_SMALL = 32'd10;

    typedef struct packed {
        logic       en;
        logic       ok;
        logic       last;
        logic       st;
        logic [7:0] b;
    } stim_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic        clk27mhz  = 1'b0;
    logic        resetn    = 1'b0;
    logic        start     = 1'b0;
    logic        init_ok   = 1'b0;
    logic        byte_en   = 1'b0;
    logic [7:0]  byte_in   = 8'd0;
    logic        byte_last = 1'b0;
    logic        ready     = 1'b0;
    logic        busy0, done0, ovf0, busy1, done1, ovf1;
    logic [31:0] cnt0, cnt1;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum0, sum1;
`endif

    stim_t stim[$];
    wr_t   got0[$], got1[$], mq[$], cg[$], ce[$];
    wr_t   prev0, prev1;
    bit    stall0, stall1;
    bit    mon_en = 1'b0;
    int    ready_mode = 0;
    int    m_cnt;
    bit    m_ovf;
    logic [31:0] m_sum;
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk27mhz = ~clk27mhz;

    sdspi_word_loader_if #(.ADDR_W(32), .WORD_BYTES(c_WB)) bus0 ();
    sdspi_word_loader_if #(.ADDR_W(32), .WORD_BYTES(c_WB)) bus1 ();
    assign bus0.wr_ready = ready;
    assign bus1.wr_ready = ready;

    sdspi_word_loader #(.WORD_BYTES(c_WB), .ADDR_W(32), .BASE_ADDR(32'd0),
                        .MAX_BYTES(c_MAX_BIG), .FIFO_DEPTH(c_DEPTH)) dut0 (
        .clk27mhz  (clk27mhz),
        .resetn    (resetn),
        .start     (start),
        .init_ok   (init_ok),
        .byte_en   (byte_en),
        .byte_in   (byte_in),
        .byte_last (byte_last),
        .wr        (bus0),
        .busy      (busy0),
        .done      (done0),
        .overflow  (ovf0),
`ifdef LOADER_CHECKSUM_EN
        .checksum  (sum0),
`endif
        .byte_count(cnt0)
    );

    sdspi_word_loader #(.WORD_BYTES(c_WB), .ADDR_W(32), .BASE_ADDR(32'd0),
                        .MAX_BYTES(c_MAX_SMALL), .FIFO_DEPTH(c_DEPTH)) dut1 (
        .clk27mhz  (clk27mhz),
        .resetn    (resetn),
        .start     (start),
        .init_ok   (init_ok),
        .byte_en   (byte_en),
        .byte_in   (byte_in),
        .byte_last (byte_last),
        .wr        (bus1),
        .busy      (busy1),
        .done      (done1),
        .overflow  (ovf1),
`ifdef LOADER_CHECKSUM_EN
        .checksum  (sum1),
`endif
        .byte_count(cnt1)
    );

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: collects transfers, checks hold-while-stalled and zero-when-empty
    always @(negedge clk27mhz) begin
        if (!mon_en) begin
            stall0 = 1'b0;
            stall1 = 1'b0;
        end else begin
            if (stall0) check("stable0", {bus0.wr_addr, bus0.wr_data, bus0.wr_strb}, prev0);
            if (stall1) check("stable1", {bus1.wr_addr, bus1.wr_data, bus1.wr_strb}, prev1);
            if (!bus0.wr_valid) check("empty_zero0", {bus0.wr_addr, bus0.wr_data, bus0.wr_strb}, 80'd0);
            if (!bus1.wr_valid) check("empty_zero1", {bus1.wr_addr, bus1.wr_data, bus1.wr_strb}, 80'd0);
            if (bus0.wr_valid && bus0.wr_ready) got0.push_back({bus0.wr_addr, bus0.wr_data, bus0.wr_strb});
            if (bus1.wr_valid && bus1.wr_ready) got1.push_back({bus1.wr_addr, bus1.wr_data, bus1.wr_strb});
            stall0 = bus0.wr_valid && !bus0.wr_ready;
            stall1 = bus1.wr_valid && !bus1.wr_ready;
            prev0  = {bus0.wr_addr, bus0.wr_data, bus0.wr_strb};
            prev1  = {bus1.wr_addr, bus1.wr_data, bus1.wr_strb};
        end
    end

    function automatic logic ready_val();
        case (ready_mode)
            0:       return 1'b1;
            1:       return ($urandom % 4) != 0;
            default: return 1'b0;
        endcase
    endfunction

    // Accepted byte i lands in word i/WB, lane i%WB; with the sink stalled
    // through the stream only the first c_DEPTH words survive.
    task automatic model(input logic [31:0] maxb, input bit ready_low);
        logic [7:0] acc[$];
        int         words;
        mq.delete();
        m_sum = 32'd0;
        for (int i = 0; i < stim.size(); i++) begin
            if (stim[i].en && stim[i].ok) begin
                acc.push_back(stim[i].b);
                m_sum += 32'(stim[i].b);
                if (stim[i].last || acc.size() == int'(maxb)) break;
            end
        end
        m_cnt = acc.size();
        words = (m_cnt + c_WB - 1) / c_WB;
        for (int w = 0; w < words; w++) begin
            wr_t e;
            e = '0;
            e.addr = 32'(w * c_WB);
            for (int l = 0; l < c_WB; l++) begin
                if (w * c_WB + l < m_cnt) begin
                    e.data[8*l +: 8] = acc[w * c_WB + l];
                    e.strb[l] = 1'b1;
                end
            end
            if (!ready_low || w < c_DEPTH) mq.push_back(e);
        end
        m_ovf = ready_low && (words > c_DEPTH);
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_nwr"}, 80'(cg.size()), 80'(ce.size()));
        for (int i = 0; i < cg.size() && i < ce.size(); i++) begin
            check({tag, "_addr"}, cg[i].addr, ce[i].addr);
            check({tag, "_data"}, cg[i].data, ce[i].data);
            check({tag, "_strb"}, cg[i].strb, ce[i].strb);
        end
    endtask

    task automatic stim_seq(input logic [7:0] first, input int n, input bit with_last);
        stim.delete();
        for (int i = 0; i < n; i++) begin
            stim.push_back('{en: 1'b1, ok: 1'b1, last: (with_last && i == n - 1),
                             st: 1'b0, b: first + 8'(i)});
        end
    endtask

    task automatic start_load();
        got0.delete();
        got1.delete();
        start = 1'b1;
        ready = ready_val();
        @(posedge clk27mhz); #1;
        start = 1'b0;
        check("load_cnt0", cnt0, 0);
        check("load_cnt1", cnt1, 0);
        check("load_busy0", busy0, 1);
        check("load_ovf0", ovf0, 0);
    endtask

    task automatic drive_stim();
        for (int i = 0; i < stim.size(); i++) begin
            byte_en   = stim[i].en;
            init_ok   = stim[i].ok;
            byte_in   = stim[i].b;
            byte_last = stim[i].last;
            start     = stim[i].st;
            ready     = ready_val();
            @(posedge clk27mhz); #1;
        end
        byte_en   = 1'b0;
        byte_last = 1'b0;
        start     = 1'b0;
        init_ok   = 1'b1;
    endtask

    task automatic wait_done();
        int c = 0;
        while (!(done0 && done1) && c < 400) begin
            ready = ready_val();
            @(posedge clk27mhz); #1;
            c++;
        end
        check("done0", done0, 1);
        check("done1", done1, 1);
        check("idle_busy0", busy0, 0);
    endtask

    task automatic verify(input bit ready_low);
        model(c_MAX_BIG, ready_low);
        cg = got0; ce = mq;
        compare_q("d0");
        check("cnt0", cnt0, m_cnt);
        check("ovf0", ovf0, m_ovf);
`ifdef LOADER_CHECKSUM_EN
        check("sum0", sum0, m_sum);
`endif
        model(c_MAX_SMALL, ready_low);
        cg = got1; ce = mq;
        compare_q("d1");
        check("cnt1", cnt1, m_cnt);
        check("ovf1", ovf1, m_ovf);
`ifdef LOADER_CHECKSUM_EN
        check("sum1", sum1, m_sum);
`endif
    endtask

    task automatic run_load(input int mode);
        ready_mode = mode;
        start_load();
        drive_stim();
        if (mode == 2) begin
            repeat (3) begin
                ready = 1'b0;
                @(posedge clk27mhz); #1;
            end
            ready_mode = 0;
        end
        wait_done();
        verify(mode == 2);
    endtask

    initial begin
        repeat (3) @(posedge clk27mhz);
        #1;
        resetn = 1'b1;
        init_ok = 1'b1;
        check("rst_valid", bus0.wr_valid, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_cnt", cnt0, 0);
        mon_en = 1'b1;

        stim_seq(8'h01, 8, 1'b1);
        run_load(0);
        if (got0.size() == 2) begin
            check("t1_w0", {got0[0].addr, got0[0].data, got0[0].strb}, {32'h0, 32'h0403_0201, 4'hF});
            check("t1_w1", {got0[1].addr, got0[1].data, got0[1].strb}, {32'h4, 32'h0807_0605, 4'hF});
        end
`ifdef LOADER_CHECKSUM_EN
        check("t1_sum", sum0, 32'h24);
`endif

        stim_seq(8'hAA, 6, 1'b1);
        run_load(1);
        check("t2_nwr", got0.size(), 2);
        if (got0.size() == 2)
            check("t2_w1", {got0[1].addr, got0[1].data, got0[1].strb}, {32'h4, 32'h0000_AFAE, 4'h3});

        // Word completing at edge N must not be visible until after edge N+1
        stim_seq(8'h11, 4, 1'b1);
        ready_mode = 2;
        start_load();
        drive_stim();
        check("lat_n", bus0.wr_valid, 0);
        @(posedge clk27mhz); #1;
        check("lat_n1", bus0.wr_valid, 1);
        check("lat_word", {bus0.wr_addr, bus0.wr_data, bus0.wr_strb}, {32'h0, 32'h1413_1211, 4'hF});
        ready_mode = 0;
        wait_done();
        verify(1'b0);

        stim_seq(8'h01, 24, 1'b1);
        run_load(2);
        check("t3_ovf", ovf0, 1);
        if (got0.size() == 4)
            check("t3_addr3", got0[3].addr, 32'hC);

        stim_seq(8'h10, 16, 1'b1);
        run_load(0);
        check("t4_cnt", cnt1, 10);
        check("t4_nwr", got1.size(), 3);
        if (got1.size() == 3)
            check("t4_w2", {got1[2].addr, got1[2].strb}, {32'h8, 4'h3});

        stim_seq(8'h50, 8, 1'b1);
        for (int i = 0; i < 3; i++) stim[i].ok = 1'b0;
        run_load(0);
        check("t5_cnt", cnt0, 5);

        // Reset in the middle of a load with queued words
        stim_seq(8'h40, 10, 1'b0);
        ready_mode = 2;
        start_load();
        drive_stim();
        check("pre_rst_valid", bus0.wr_valid, 1);
        mon_en = 1'b0;
        resetn = 1'b0;
        @(posedge clk27mhz); #1;
        check("mid_rst_valid0", bus0.wr_valid, 0);
        check("mid_rst_valid1", bus1.wr_valid, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_done", done0, 0);
        check("mid_rst_cnt", cnt0, 0);
        resetn = 1'b1;
        @(posedge clk27mhz); #1;
        mon_en = 1'b1;

        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(1, 40);
            stim.delete();
            for (int i = 0; i < n; i++) begin
                stim.push_back('{en: ($urandom % 4) != 0, ok: ($urandom % 8) != 0, last: 1'b0,
                                 st: (i < 8) && (($urandom % 16) == 0), b: 8'($urandom)});
            end
            stim.push_back('{en: 1'b1, ok: 1'b1, last: 1'b1, st: 1'b0, b: 8'($urandom)});
            run_load(int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
